// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

    // Owner encoding doubles as the requester index into the req/grant vectors.
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: req[0]=IFU, req[1]=LSU, one-hot grant.
// Latency: grant is combinational from req; last_grant updates on advance.
// Backpressure: none; advance tells it a grant was consumed.
// Ports: clock, reset (async, active-high), req[1:0], advance, grant[1:0].
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0 = IFU was granted last, 1 = LSU was granted last.
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: whoever did not win last time goes now.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (advance) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM port between IFU (reads) and LSU (loads/stores).
// Latency: accept in T, response pulse in T+1; one transaction per two cycles.
// Backpressure: req_ready only in idle cycle to the round-robin winner; responses cannot stall.
// Ports: clock/reset, ifu_req_*/ifu_resp_*, lsu_req_*/lsu_resp_*, mem_* to the RAM.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wbmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wbmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state, state_nxt;
    arb_owner_t owner;
    logic       owner_wen;
    logic [1:0] req;
    logic [1:0] grant;
    logic       accept;

    // Requests are only offered to the picker in the idle cycle and outside
    // reset, so a zero grant covers "busy", "in reset" and "nobody asking".
    assign req    = (state == ARB_IDLE && !reset) ? {lsu_req_valid, ifu_req_valid} : 2'b00;
    assign accept = |grant;

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .grant   (grant)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IFU;
            owner_wen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner     <= grant[1] ? OWN_LSU : OWN_IFU;
                owner_wen <= grant[1] & lsu_wen;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        mem_wen        = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wbmask     = '0;

        case (state)
            ARB_IDLE: begin
                ifu_req_ready = grant[0];
                lsu_req_ready = grant[1];
                if (grant[1]) begin
                    mem_wen    = lsu_wen;
                    mem_addr   = lsu_addr;
                    mem_wdata  = lsu_wdata;
                    mem_wbmask = lsu_wbmask;
                end else if (grant[0]) begin
                    mem_addr   = ifu_addr;
                end
                if (accept) begin
                    state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                // RAM port is idle this cycle; it is presenting last cycle's read.
                state_nxt = ARB_IDLE;
                if (owner == OWN_IFU) begin
                    ifu_resp_valid = 1'b1;
                    ifu_rdata      = mem_rdata;
                end else begin
                    lsu_resp_valid = 1'b1;
                    lsu_rdata      = owner_wen ? '0 : mem_rdata;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-masked synchronous-read RAM model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wbmask;
    logic        mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wbmask;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram_q [0:255];

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_wen        (lsu_wen),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wbmask     (lsu_wbmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wbmask     (mem_wbmask),
        .mem_rdata      (mem_rdata)
    );

    // RAM model: synchronous read, byte-masked write, returns 0 on a write cycle.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_rdata <= 32'h0;
        end else if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wbmask[b]) ram_q[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            mem_rdata <= 32'h0;
        end else begin
            mem_rdata <= ram_q[mem_addr[9:2]];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive point is 1 ns after a rising edge; sample point is the falling edge.
    task automatic to_sample();
        #4;
    endtask

    task automatic to_drive();
        @(posedge clock);
        #1;
    endtask

    task automatic check_mem_idle(input string tag);
        check_val({tag, ".mem_wen"},    mem_wen,    0);
        check_val({tag, ".mem_addr"},   mem_addr,   0);
        check_val({tag, ".mem_wdata"},  mem_wdata,  0);
        check_val({tag, ".mem_wbmask"}, mem_wbmask, 0);
    endtask

    // Request held through the response cycle to show it is not re-accepted there.
    task automatic lsu_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input logic [31:0] exp, input string tag);
        lsu_req_valid = 1'b1; lsu_wen = wen; lsu_addr = addr; lsu_wdata = wdata; lsu_wbmask = mask;
        to_sample();
        check_val({tag, ".rdy"},      lsu_req_ready, 1);
        check_val({tag, ".ifu_rdy"},  ifu_req_ready, 0);
        check_val({tag, ".mem_wen"},  mem_wen,       wen);
        check_val({tag, ".mem_addr"}, mem_addr,      addr);
        check_val({tag, ".mem_wbm"},  mem_wbmask,    mask);
        if (wen) check_val({tag, ".mem_wdata"}, mem_wdata, wdata);
        to_drive();
        to_sample();
        check_val({tag, ".resp_vld"},  lsu_resp_valid, 1);
        check_val({tag, ".rdata"},     lsu_rdata,      exp);
        check_val({tag, ".ifu_resp"},  ifu_resp_valid, 0);
        check_val({tag, ".busy_rdy"},  lsu_req_ready,  0);
        check_mem_idle({tag, ".resp"});
        to_drive();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wbmask = 4'h0; lsu_wdata = 32'h0;
    endtask

    task automatic ifu_txn(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        ifu_req_valid = 1'b1; ifu_addr = addr;
        to_sample();
        check_val({tag, ".rdy"},      ifu_req_ready, 1);
        check_val({tag, ".lsu_rdy"},  lsu_req_ready, 0);
        check_val({tag, ".mem_wen"},  mem_wen,       0);
        check_val({tag, ".mem_addr"}, mem_addr,      addr);
        check_val({tag, ".mem_wbm"},  mem_wbmask,    0);
        check_val({tag, ".mem_wd"},   mem_wdata,     0);
        to_drive();
        to_sample();
        check_val({tag, ".resp_vld"}, ifu_resp_valid, 1);
        check_val({tag, ".rdata"},    ifu_rdata,      exp);
        check_val({tag, ".lsu_resp"}, lsu_resp_valid, 0);
        check_val({tag, ".lsu_rd"},   lsu_rdata,      0);
        check_val({tag, ".busy_rdy"}, ifu_req_ready,  0);
        to_drive();
        ifu_req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram_q[i] = 32'h0;
        ram_q[0] = 32'h0000_0013;          // 0x8000_0000

        // Both requesters valid while reset is held: nothing may be granted.
        reset = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'h0; lsu_wbmask = 4'h0;
        to_drive();
        to_sample();
        check_val("rst.ifu_rdy",  ifu_req_ready,  0);
        check_val("rst.lsu_rdy",  lsu_req_ready,  0);
        check_val("rst.ifu_resp", ifu_resp_valid, 0);
        check_val("rst.lsu_resp", lsu_resp_valid, 0);
        check_val("rst.ifu_rd",   ifu_rdata,      0);
        check_val("rst.lsu_rd",   lsu_rdata,      0);
        check_mem_idle("rst");
        to_drive();
        reset = 1'b0;

        // Continuous contention from reset: LSU, IFU, LSU, IFU on cycles 0,2,4,6.
        for (int k = 0; k < 8; k++) begin
            to_sample();
            check_val($sformatf("alt%0d.lsu_rdy", k),  lsu_req_ready,  (k % 4) == 0);
            check_val($sformatf("alt%0d.ifu_rdy", k),  ifu_req_ready,  (k % 4) == 2);
            check_val($sformatf("alt%0d.lsu_resp", k), lsu_resp_valid, (k % 4) == 1);
            check_val($sformatf("alt%0d.ifu_resp", k), ifu_resp_valid, (k % 4) == 3);
            if (k % 4 == 3) check_val("alt.ifu_rdata", ifu_rdata, 32'h13);
            if (k % 4 == 0) check_val("alt.mem_addr",  mem_addr,  32'h8000_0100);
            if (k % 4 == 2) check_val("alt.mem_addr",  mem_addr,  32'h8000_0000);
            to_drive();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // Quiet bus for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            to_sample();
            check_mem_idle("idle");
            check_val("idle.ifu_rdy", ifu_req_ready, 0);
            check_val("idle.lsu_rdy", lsu_req_ready, 0);
            to_drive();
        end

        ifu_txn(32'h8000_0000, 32'h0000_0013, "ifu_rd");
        lsu_txn(1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, "st_full");
        lsu_txn(1'b0, 32'h8000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, "ld_full");
        lsu_txn(1'b1, 32'h8000_0200, 32'hFFFF_FFFF, 4'hF, 32'h0, "st_ones");
        lsu_txn(1'b1, 32'h8000_0200, 32'h1122_3344, 4'h3, 32'h0, "st_mask3");
        lsu_txn(1'b0, 32'h8000_0200, 32'h0, 4'h0, 32'hFFFF_3344, "ld_mask3");

        // LSU wins (last_grant=LSU), then reset lands in the response cycle.
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0100;
        to_sample();
        check_val("rr.lsu_rdy", lsu_req_ready, 1);
        to_drive();
        lsu_req_valid = 1'b0;
        reset = 1'b1;
        to_sample();
        check_val("rr.resp_lsu", lsu_resp_valid, 0);
        check_val("rr.resp_ifu", ifu_resp_valid, 0);
        check_val("rr.lsu_rd",   lsu_rdata,      0);
        check_mem_idle("rr");
        to_drive();
        reset = 1'b0;
        to_sample();
        check_val("rr.post_lsu_resp", lsu_resp_valid, 0);
        check_val("rr.post_ifu_resp", ifu_resp_valid, 0);
        check_mem_idle("rr.post");
        to_drive();
        // last_grant back to IFU, so contention goes to LSU.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        to_sample();
        check_val("rr.lg_lsu_rdy", lsu_req_ready, 1);
        check_val("rr.lg_ifu_rdy", ifu_req_ready, 0);
        to_drive();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        to_sample();
        check_val("rr.lg_resp", lsu_resp_valid, 1);
        check_val("rr.lg_rd",   lsu_rdata,      32'hDEAD_BEEF);
        to_drive();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
